// File: rtl/conv_rdma.sv
// Feature read DMA: walks a CSR-described feature cube, issues credit-limited MCIF burst reads
// and streams the returned beats to the MAC side. Define CONV_RDMA_PERF_EN for the busy-cycle counter.
module conv_rdma #(
    parameter int DW         = 8,
    parameter int TOUT       = 16,
    parameter int W_W        = 12,
    parameter int H_W        = 12,
    parameter int C_W        = 8,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdma_start,
    input  logic [W_W-1:0]       w_rdma,
    input  logic [H_W-1:0]       h_rdma,
    input  logic [C_W-1:0]       ch_rdma_div_Tout,
    input  logic [31:0]          feature_rdma_base_addr,
    input  logic [31:0]          feature_rdma_surface_stride,
    input  logic [31:0]          feature_rdma_line_stride,
    output logic                 rdma_busy,
    output logic                 rdma_done,
    output logic [31:0]          rdma_cycle_cnt,
    output logic                 conv2mcif_rd_req_vld,
    input  logic                 conv2mcif_rd_req_rdy,
    output logic [39:0]          conv2mcif_rd_req_pd,
    input  logic                 mcif2conv_rd_rsp_vld,
    input  logic [TOUT*DW-1:0]   mcif2conv_rd_rsp_pd,
    output logic                 dat_out_vld,
    output logic [TOUT*DW-1:0]   dat_out_pd,
    input  logic                 dat_out_rdy
);

    localparam int BW         = TOUT * DW;
    localparam int BEAT_SHIFT = $clog2(BW / 8);
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int CR_W       = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_DONE} state_t;

    state_t            state;
    logic [W_W-1:0]    w_r, x_r, rem_pix, burst_len, x_next;
    logic [H_W-1:0]    h_r, y_r;
    logic [C_W-1:0]    ch_r, c_r;
    logic [31:0]       ls_r, ss_r, line_ptr, surf_ptr, req_addr;
    logic [CR_W-1:0]   credit, credit_nxt;
    logic [AW:0]       wr_ptr, rd_ptr;
    logic [BW-1:0]     mem [FIFO_DEPTH];
    logic              line_end, surf_end, last_req, req_fire, out_fire, fifo_full, zero_dim;

    // Burst never crosses a line: clip to the pixels left on the current line.
    assign rem_pix   = w_r - x_r;
    assign burst_len = (rem_pix > W_W'(MAX_BURST)) ? W_W'(MAX_BURST) : rem_pix;
    assign x_next    = x_r + burst_len;
    assign line_end  = (x_next == w_r);
    assign surf_end  = line_end && (y_r == h_r - H_W'(1));
    assign last_req  = surf_end && (c_r == ch_r - C_W'(1));
    assign zero_dim  = (w_rdma == '0) || (h_rdma == '0) || (ch_rdma_div_Tout == '0);

    assign conv2mcif_rd_req_vld = (state == S_REQ) && (W_W'(credit) >= burst_len);
    assign conv2mcif_rd_req_pd  = {8'(burst_len - W_W'(1)), req_addr};
    assign req_fire             = conv2mcif_rd_req_vld && conv2mcif_rd_req_rdy;
    assign out_fire             = dat_out_vld && dat_out_rdy;

    // Credit tracks free FIFO slots including beats still in flight from MCIF.
    assign credit_nxt = credit - (req_fire ? CR_W'(burst_len) : '0) + (out_fire ? CR_W'(1) : '0);

    assign rdma_busy   = (state != S_IDLE);
    assign rdma_done   = (state == S_DONE);
    assign dat_out_vld = (wr_ptr != rd_ptr);
    assign dat_out_pd  = mem[rd_ptr[AW-1:0]];
    assign fifo_full   = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            w_r      <= '0;
            h_r      <= '0;
            ch_r     <= '0;
            ls_r     <= '0;
            ss_r     <= '0;
            x_r      <= '0;
            y_r      <= '0;
            c_r      <= '0;
            line_ptr <= '0;
            surf_ptr <= '0;
            req_addr <= '0;
            credit   <= CR_W'(FIFO_DEPTH);
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            credit <= credit_nxt;
            if (mcif2conv_rd_rsp_vld) wr_ptr <= wr_ptr + 1'b1;
            if (out_fire)             rd_ptr <= rd_ptr + 1'b1;
            unique case (state)
                S_IDLE: if (rdma_start) begin
                    w_r      <= w_rdma;
                    h_r      <= h_rdma;
                    ch_r     <= ch_rdma_div_Tout;
                    ls_r     <= feature_rdma_line_stride;
                    ss_r     <= feature_rdma_surface_stride;
                    x_r      <= '0;
                    y_r      <= '0;
                    c_r      <= '0;
                    line_ptr <= feature_rdma_base_addr;
                    surf_ptr <= feature_rdma_base_addr;
                    req_addr <= feature_rdma_base_addr;
                    state    <= zero_dim ? S_DONE : S_REQ;
                end
                S_REQ: if (req_fire) begin
                    if (!line_end) begin
                        x_r      <= x_next;
                        req_addr <= req_addr + (32'(burst_len) << BEAT_SHIFT);
                    end else if (!surf_end) begin
                        x_r      <= '0;
                        y_r      <= y_r + H_W'(1);
                        line_ptr <= line_ptr + ls_r;
                        req_addr <= line_ptr + ls_r;
                    end else begin
                        x_r      <= '0;
                        y_r      <= '0;
                        c_r      <= c_r + C_W'(1);
                        surf_ptr <= surf_ptr + ss_r;
                        line_ptr <= surf_ptr + ss_r;
                        req_addr <= surf_ptr + ss_r;
                    end
                    if (last_req) state <= S_DRAIN;
                end
                // Credit back at full depth means every requested beat has left downstream.
                S_DRAIN: if (credit_nxt == CR_W'(FIFO_DEPTH)) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the FIFO storage has no reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (mcif2conv_rd_rsp_vld) mem[wr_ptr[AW-1:0]] <= mcif2conv_rd_rsp_pd;
    end

    assert property (@(posedge clk) disable iff (rst) !(mcif2conv_rd_rsp_vld && fifo_full))
        else $error("conv_rdma: response beat written into a full FIFO");

`ifdef CONV_RDMA_PERF_EN
    logic [31:0] cycle_cnt;
    always_ff @(posedge clk) begin
        if (rst)                                cycle_cnt <= '0;
        else if (state == S_IDLE && rdma_start) cycle_cnt <= '0;
        else if (rdma_busy)                     cycle_cnt <= cycle_cnt + 32'd1;
    end
    assign rdma_cycle_cnt = cycle_cnt;
`else
    assign rdma_cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_rdma.sv
// Randomised scoreboard bench for conv_rdma: a cube-walk reference model predicts requests and
// beats, an MCIF responder returns address-derived data, and a monitor checks both streams.
module tb_conv_rdma;
    localparam int DW = 8, TOUT = 16, BW = DW * TOUT, BEAT_BYTES = BW / 8;
    localparam int W_W = 12, H_W = 12, C_W = 8, MAX_BURST = 16, FIFO_DEPTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rdma_start = 1'b0;
    logic [W_W-1:0]   w_rdma = '0;
    logic [H_W-1:0]   h_rdma = '0;
    logic [C_W-1:0]   ch_rdma_div_Tout = '0;
    logic [31:0]      feature_rdma_base_addr = '0;
    logic [31:0]      feature_rdma_surface_stride = '0;
    logic [31:0]      feature_rdma_line_stride = '0;
    logic             rdma_busy, rdma_done;
    logic [31:0]      rdma_cycle_cnt;
    logic             conv2mcif_rd_req_vld;
    logic             conv2mcif_rd_req_rdy = 1'b0;
    logic [39:0]      conv2mcif_rd_req_pd;
    logic             mcif2conv_rd_rsp_vld = 1'b0;
    logic [BW-1:0]    mcif2conv_rd_rsp_pd = '0;
    logic             dat_out_vld;
    logic [BW-1:0]    dat_out_pd;
    logic             dat_out_rdy = 1'b0;

    conv_rdma #(.DW(DW), .TOUT(TOUT), .W_W(W_W), .H_W(H_W), .C_W(C_W),
                .MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .rdma_start(rdma_start),
        .w_rdma(w_rdma), .h_rdma(h_rdma), .ch_rdma_div_Tout(ch_rdma_div_Tout),
        .feature_rdma_base_addr(feature_rdma_base_addr),
        .feature_rdma_surface_stride(feature_rdma_surface_stride),
        .feature_rdma_line_stride(feature_rdma_line_stride),
        .rdma_busy(rdma_busy), .rdma_done(rdma_done), .rdma_cycle_cnt(rdma_cycle_cnt),
        .conv2mcif_rd_req_vld(conv2mcif_rd_req_vld), .conv2mcif_rd_req_rdy(conv2mcif_rd_req_rdy),
        .conv2mcif_rd_req_pd(conv2mcif_rd_req_pd),
        .mcif2conv_rd_rsp_vld(mcif2conv_rd_rsp_vld), .mcif2conv_rd_rsp_pd(mcif2conv_rd_rsp_pd),
        .dat_out_vld(dat_out_vld), .dat_out_pd(dat_out_pd), .dat_out_rdy(dat_out_rdy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int req_hs_cnt = 0, done_cnt = 0, busy_cycles = 0;
    int req_rdy_pct = 100, out_rdy_pct = 100, rsp_pct = 100;
    bit manual = 1'b0;
    bit hold_pending = 1'b0;
    logic [39:0]   held_pd;
    logic [31:0]   salt = 32'h0;
    logic [39:0]   exp_req_q[$];
    logic [BW-1:0] exp_beat_q[$];
    logic [31:0]   rsp_q[$];

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] beat_data(logic [31:0] a);
        return {a, ~a, a ^ salt, a + salt};
    endfunction

    // Reference model: the cube in walk order, split into line-bounded bursts.
    task automatic build_expect(int w, int h, int ch, logic [31:0] base, logic [31:0] ss, logic [31:0] ls);
        for (int c = 0; c < ch; c++) begin
            for (int y = 0; y < h; y++) begin
                int x;
                x = 0;
                while (x < w) begin
                    int len;
                    logic [31:0] addr;
                    len  = (w - x > MAX_BURST) ? MAX_BURST : w - x;
                    addr = base + 32'(c) * ss + 32'(y) * ls + 32'(x * BEAT_BYTES);
                    exp_req_q.push_back({8'(len - 1), addr});
                    for (int b = 0; b < len; b++)
                        exp_beat_q.push_back(beat_data(addr + 32'(b * BEAT_BYTES)));
                    x += len;
                end
            end
        end
    endtask

    // Ready generators and MCIF responder; responses follow accepted requests in order.
    initial begin : driver
        forever begin
            @(posedge clk); #1;
            if (!manual) begin
                conv2mcif_rd_req_rdy = (int'($urandom_range(99)) < req_rdy_pct);
                dat_out_rdy          = (int'($urandom_range(99)) < out_rdy_pct);
            end
            if (rst || rsp_q.size() == 0 || int'($urandom_range(99)) >= rsp_pct) begin
                mcif2conv_rd_rsp_vld = 1'b0;
            end else begin
                mcif2conv_rd_rsp_vld = 1'b1;
                mcif2conv_rd_rsp_pd  = beat_data(rsp_q.pop_front());
            end
        end
    end

    initial begin : monitor
        logic [39:0]   exp_pd;
        logic [BW-1:0] exp_dat;
        int            len;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pending = 1'b0;
            end else begin
                if (rdma_busy) busy_cycles++;
                if (rdma_done) done_cnt++;
                if (hold_pending) begin
                    check("req_hold_vld", conv2mcif_rd_req_vld, 1'b1);
                    check("req_hold_pd", conv2mcif_rd_req_pd, held_pd);
                end
                hold_pending = conv2mcif_rd_req_vld && !conv2mcif_rd_req_rdy;
                held_pd      = conv2mcif_rd_req_pd;
                if (conv2mcif_rd_req_vld && conv2mcif_rd_req_rdy) begin
                    req_hs_cnt++;
                    if (exp_req_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL req_unexpected: got pd %h, no request expected", conv2mcif_rd_req_pd);
                    end else begin
                        exp_pd = exp_req_q.pop_front();
                        check("req_pd", conv2mcif_rd_req_pd, exp_pd);
                    end
                    len = int'(conv2mcif_rd_req_pd[39:32]) + 1;
                    for (int b = 0; b < len; b++)
                        rsp_q.push_back(conv2mcif_rd_req_pd[31:0] + 32'(b * BEAT_BYTES));
                end
                if (dat_out_vld && dat_out_rdy) begin
                    if (exp_beat_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL beat_unexpected: got %h, no beat expected", dat_out_pd);
                    end else begin
                        exp_dat = exp_beat_q.pop_front();
                        check("beat_data", dat_out_pd, exp_dat);
                    end
                end
            end
        end
    end

    task automatic start_run(int w, int h, int ch, logic [31:0] base, logic [31:0] ss, logic [31:0] ls);
        salt = $urandom;
        build_expect(w, h, ch, base, ss, ls);
        done_cnt = 0; req_hs_cnt = 0; busy_cycles = 0;
        @(posedge clk); #1;
        w_rdma = W_W'(w); h_rdma = H_W'(h); ch_rdma_div_Tout = C_W'(ch);
        feature_rdma_base_addr = base; feature_rdma_surface_stride = ss; feature_rdma_line_stride = ls;
        rdma_start = 1'b1;
        @(posedge clk); #1;
        rdma_start = 1'b0;
        @(negedge clk);
        check("first_req_latency", conv2mcif_rd_req_vld, 1'b1);
    endtask

    task automatic finish_run(string tag, int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (rdma_done) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s_done_timeout: no done within %0d cycles, %0d beats outstanding",
                     tag, budget, exp_beat_q.size());
            @(posedge clk); #1 rst = 1'b1;
            exp_req_q.delete(); exp_beat_q.delete(); rsp_q.delete();
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            return;
        end
        check({tag, "_beats_left_at_done"}, exp_beat_q.size(), 0);
        repeat (3) @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_reqs_left"}, exp_req_q.size(), 0);
        check({tag, "_busy_after"}, rdma_busy, 1'b0);
`ifdef CONV_RDMA_PERF_EN
        check({tag, "_cycle_cnt"}, rdma_cycle_cnt, busy_cycles);
        repeat (4) @(negedge clk);
        check({tag, "_cycle_cnt_hold"}, rdma_cycle_cnt, busy_cycles);
`else
        check({tag, "_cycle_cnt_zero"}, rdma_cycle_cnt, 32'd0);
`endif
    endtask

    initial begin : main
        bit d1, d2;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", rdma_busy, 1'b0);
        check("rst_done", rdma_done, 1'b0);
        check("rst_req_vld", conv2mcif_rd_req_vld, 1'b0);
        check("rst_out_vld", dat_out_vld, 1'b0);
        check("rst_cycle_cnt", rdma_cycle_cnt, 32'd0);

        // Two lines of 20 pixels; a start arriving mid-run must not disturb it.
        start_run(20, 2, 1, 32'h1000, 32'h0, 32'h400);
        repeat (3) @(posedge clk);
        #1;
        w_rdma = 12'd7; h_rdma = 12'd5; feature_rdma_base_addr = 32'hdead_0000;
        rdma_start = 1'b1;
        @(posedge clk); #1 rdma_start = 1'b0;
        finish_run("line_split", 2000);
        check("line_split_req_count", req_hs_cnt, 4);

        start_run(4, 1, 3, 32'h0002_0040, 32'h10000, 32'h0);
        finish_run("surfaces", 2000);
        check("surfaces_req_count", req_hs_cnt, 3);

        // Downstream stalled: credit allows only two 16-beat requests into a 32-deep FIFO.
        manual = 1'b1; conv2mcif_rd_req_rdy = 1'b1; dat_out_rdy = 1'b0;
        start_run(64, 1, 1, 32'h8000, 32'h0, 32'h0);
        repeat (60) @(negedge clk);
        check("stall_req_count", req_hs_cnt, 2);
        check("stall_req_vld", conv2mcif_rd_req_vld, 1'b0);
        check("stall_out_vld", dat_out_vld, 1'b1);
        @(posedge clk); #1 dat_out_rdy = 1'b1;
        finish_run("credit", 2000);
        check("credit_req_count", req_hs_cnt, 4);

        // Request held off by MCIF for five cycles.
        conv2mcif_rd_req_rdy = 1'b0; dat_out_rdy = 1'b1;
        start_run(4, 1, 1, 32'h4000_0000, 32'h0, 32'h0);
        repeat (5) begin
            @(negedge clk);
            check("held_req_vld", conv2mcif_rd_req_vld, 1'b1);
        end
        @(posedge clk); #1 conv2mcif_rd_req_rdy = 1'b1;
        finish_run("held", 2000);
        check("held_req_count", req_hs_cnt, 1);

        // Zero width: done straight away, and a start seen while in DONE is ignored.
        done_cnt = 0; req_hs_cnt = 0;
        @(posedge clk); #1;
        w_rdma = 12'd0; h_rdma = 12'd1; ch_rdma_div_Tout = 8'd1; rdma_start = 1'b1;
        @(posedge clk); #1 w_rdma = 12'd4;
        @(negedge clk); d1 = rdma_done;
        @(posedge clk); #1 rdma_start = 1'b0;
        @(negedge clk); d2 = rdma_done;
        check("zero_done_within_2", d1 | d2, 1'b1);
        repeat (15) @(negedge clk);
        check("zero_req_count", req_hs_cnt, 0);
        check("zero_done_pulses", done_cnt, 1);
        check("zero_busy_after", rdma_busy, 1'b0);

        // Single beat with an immediate response (cycle counter reference run).
        start_run(1, 1, 1, 32'h0000_0100, 32'h0, 32'h0);
        finish_run("single", 200);

        // Randomised cubes, strides and handshake pressure.
        manual = 1'b0;
        for (int t = 0; t < 6; t++) begin
            req_rdy_pct = int'($urandom_range(100, 30));
            out_rdy_pct = int'($urandom_range(100, 30));
            rsp_pct     = int'($urandom_range(100, 40));
            start_run(int'($urandom_range(40, 1)), int'($urandom_range(3, 1)), int'($urandom_range(3, 1)),
                      $urandom, $urandom, $urandom);
            finish_run("random", 6000);
        end

        // Reset mid-run returns the block to its reset state.
        start_run(64, 2, 1, 32'h10_0000, 32'h0, 32'h1000);
        repeat (20) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        exp_req_q.delete(); exp_beat_q.delete(); rsp_q.delete();
        repeat (2) @(negedge clk);
        check("midrst_busy", rdma_busy, 1'b0);
        check("midrst_req_vld", conv2mcif_rd_req_vld, 1'b0);
        check("midrst_out_vld", dat_out_vld, 1'b0);
        check("midrst_done", rdma_done, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        start_run(36, 2, 2, 32'h20_0000, 32'h8000, 32'h800);
        finish_run("after_rst", 6000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
